// File: rtl/downcount_pkg.sv
// downcount_timer shared types and helpers.
// Optional build: DOWNCOUNT_AUTORELOAD_EN (periodic mode).
package downcount_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int unsigned clamp_load(
    input int unsigned value,
    input int unsigned n
  );
    return (value > n - 1) ? n - 1 : value;
  endfunction

endpackage

// File: rtl/downcount_timer_if.sv
// downcount_timer control/status bundle.
// Optional build: DOWNCOUNT_AUTORELOAD_EN (same signal set).
interface downcount_timer_if #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
);
  logic         load;
  logic [W-1:0] load_val;
  logic         enable;
  logic         stop;
  logic [W-1:0] val;
  logic         last;
  logic         busy;
  logic         done;

  modport master (
    output load, load_val, enable, stop,
    input  val, last, busy, done
  );

  modport slave (
    input  load, load_val, enable, stop,
    output val, last, busy, done
  );
endinterface

// File: rtl/downcount_timer.sv
// Loadable down-counter with last-count flag and done pulse.
// Optional build: DOWNCOUNT_AUTORELOAD_EN (periodic reload).
module downcount_timer
  import downcount_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_enable,
  input  logic         i_stop,
  output logic [W-1:0] o_val,
  output logic         o_last,
  output logic         o_busy,
  output logic         o_done
);

  state_t       state_q, state_d;
  logic [W-1:0] val_q, val_d;
  logic [W-1:0] rld_q, rld_d;
  logic [W-1:0] ld_val;
  logic         val_zero;

  assign ld_val   = W'(clamp_load(32'(i_load_val), N));
  assign val_zero = (val_q == '0);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rld_d   = rld_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_load) begin
          val_d   = ld_val;
          rld_d   = ld_val;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_load) begin
          val_d = ld_val;
          rld_d = ld_val;
        end else if (i_enable) begin
          if (!val_zero) begin
            val_d = val_q - 1'b1;
          end else begin
`ifdef DOWNCOUNT_AUTORELOAD_EN
            val_d = rld_q;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (i_load) begin
          val_d   = ld_val;
          rld_d   = ld_val;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      val_q <= '0;
      rld_q <= '0;
    end else begin
      val_q <= val_d;
      rld_q <= rld_d;
    end
  end

  assign o_val  = val_q;
  assign o_busy = (state_q == S_RUN);
  assign o_last = o_busy && val_zero;

`ifdef DOWNCOUNT_AUTORELOAD_EN
  // Tick marks the reload cycle itself
  assign o_done = o_last && i_enable && !i_stop && !i_load;
`else
  assign o_done = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_downcount_timer.sv
// Randomized/directed bench for downcount_timer (N=16 and N=12).
// Optional build: DOWNCOUNT_AUTORELOAD_EN (model follows it).
module tb_downcount_timer;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] lv = '0;
  logic       en = 1'b0;
  logic       st = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  downcount_timer_if #(.N(16)) ifa ();
  downcount_timer_if #(.N(12)) ifb ();

  assign ifa.load     = ld;
  assign ifa.load_val = lv;
  assign ifa.enable   = en;
  assign ifa.stop     = st;
  assign ifb.load     = ld;
  assign ifb.load_val = lv;
  assign ifb.enable   = en;
  assign ifb.stop     = st;

  downcount_timer #(.N(16)) dut16 (
    .clk        (clk),
    .areset_n   (areset_n),
    .i_load     (ifa.load),
    .i_load_val (ifa.load_val),
    .i_enable   (ifa.enable),
    .i_stop     (ifa.stop),
    .o_val      (ifa.val),
    .o_last     (ifa.last),
    .o_busy     (ifa.busy),
    .o_done     (ifa.done)
  );

  downcount_timer #(.N(12)) dut12 (
    .clk        (clk),
    .areset_n   (areset_n),
    .i_load     (ifb.load),
    .i_load_val (ifb.load_val),
    .i_enable   (ifb.enable),
    .i_stop     (ifb.stop),
    .o_val      (ifb.val),
    .o_last     (ifb.last),
    .o_busy     (ifb.busy),
    .o_done     (ifb.done)
  );

  logic [6:0] obs [2];
  assign obs[0] = {ifa.val, ifa.last, ifa.busy, ifa.done};
  assign obs[1] = {ifb.val, ifb.last, ifb.busy, ifb.done};

  // Reference model: remaining count, running flag, pending done pulse
  int mod_n [2] = '{16, 12};
  int m_val [2];
  int m_rld [2];
  bit m_run [2];
  bit m_pend [2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_rld[k] = 0;
      m_run[k] = 0; m_pend[k] = 0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      int c;
      c = (int'(lv) > mod_n[k] - 1) ? mod_n[k] - 1 : int'(lv);
      if (m_pend[k]) begin
        m_pend[k] = 0;
        if (ld) begin
          m_run[k] = 1; m_val[k] = c; m_rld[k] = c;
        end
      end else if (!m_run[k]) begin
        if (ld) begin
          m_run[k] = 1; m_val[k] = c; m_rld[k] = c;
        end
      end else if (st) begin
        m_run[k] = 0;
      end else if (ld) begin
        m_val[k] = c; m_rld[k] = c;
      end else if (en) begin
        if (m_val[k] > 0) m_val[k] = m_val[k] - 1;
`ifdef DOWNCOUNT_AUTORELOAD_EN
        else m_val[k] = m_rld[k];
`else
        else begin
          m_run[k] = 0; m_pend[k] = 1;
        end
`endif
      end
    end
  endtask

  function automatic logic [6:0] exp_vec(input int k);
    logic [3:0] v;
    logic       d;
    v = m_val[k][3:0];
`ifdef DOWNCOUNT_AUTORELOAD_EN
    d = m_run[k] && m_val[k] == 0 && en && !st && !ld;
`else
    d = m_pend[k];
`endif
    return {v, m_run[k] && m_val[k] == 0, m_run[k], d};
  endfunction

  task automatic drive(input logic l, input int v,
                       input logic e, input logic s);
    ld = l; lv = 4'(v); en = e; st = s;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs[k] !== 7'h00) begin
        n_fail++;
        $display("FAIL reset dut%0d got=%h exp=00", k, obs[k]);
      end
    end
    areset_n = 1'b1;
    drive(0, 0, 1, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs[k] !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL reset_idle dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_count_basic();
    int first = -1;
    drive(1, 5, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL basic c%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
        end
      end
      if (ifa.done && first < 0) first = i;
      tick();
    end
    n_chk++;
    if (first !== 6) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d exp=6", first);
    end
    n_chk++;
    if (ifa.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_after got=%b exp=0", ifa.busy);
    end
  endtask

  task automatic test_clamp();
    int f16 = -1;
    int f12 = -1;
    int maxv = 0;
    drive(1, 15, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    n_chk++;
    if (ifb.val !== 4'd11) begin
      n_fail++;
      $display("FAIL clamp_load got=%0d exp=11", ifb.val);
    end
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL clamp c%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
        end
      end
      if (int'(ifb.val) > maxv) maxv = int'(ifb.val);
      if (ifa.done && f16 < 0) f16 = i;
      if (ifb.done && f12 < 0) f12 = i;
      tick();
    end
    n_chk++;
    if (f12 !== 12) begin
      n_fail++;
      $display("FAIL clamp_latency12 got=%0d exp=12", f12);
    end
    n_chk++;
    if (f16 !== 16) begin
      n_fail++;
      $display("FAIL clamp_latency16 got=%0d exp=16", f16);
    end
    n_chk++;
    if (maxv > 11) begin
      n_fail++;
      $display("FAIL clamp_max got=%0d exp<=11", maxv);
    end
  endtask

  task automatic test_enable_toggle();
    int en_cnt = 0;
    int rec = -1;
    drive(1, 7, 1, 0);
    tick();
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL toggle c%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
        end
      end
      if (ifa.done && rec < 0) rec = en_cnt;
      drive(0, 0, (i % 2) == 0, 0);
      if (en) en_cnt++;
      tick();
    end
    n_chk++;
    if (rec !== 8) begin
      n_fail++;
      $display("FAIL toggle_enabled_cycles got=%0d exp=8", rec);
    end
  endtask

  task automatic test_stop_reload();
    for (int pass = 0; pass < 2; pass++) begin
      int guard = 0;
      drive(1, 9, 1, 0);
      tick();
      drive(0, 0, 1, 0);
      while (ifa.val !== 4'd4 && guard < 20) begin
        tick();
        guard++;
      end
      n_chk++;
      if (guard >= 20) begin
        n_fail++;
        $display("FAIL stop_reach4 got=%0d exp=4", ifa.val);
      end
      if (pass == 0) drive(0, 0, 1, 1);
      else drive(1, 2, 1, 0);
      tick();
      drive(0, 0, 1, 0);
      n_chk++;
      if (pass == 0 && (ifa.val !== 4'd4 || ifa.busy !== 1'b0)) begin
        n_fail++;
        $display("FAIL stop_hold got=%0d/%b exp=4/0", ifa.val, ifa.busy);
      end else if (pass == 1 && (ifa.val !== 4'd2 || ifa.busy !== 1'b1)) begin
        n_fail++;
        $display("FAIL reload_mid got=%0d/%b exp=2/1", ifa.val, ifa.busy);
      end
      for (int i = 0; i < 6; i++) begin
        for (int k = 0; k < 2; k++) begin
          n_chk++;
          if (obs[k] !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL stop%0d c%0d dut%0d got=%h exp=%h", pass, i, k, obs[k], exp_vec(k));
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    drive(1, 1, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    while (ifa.done !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    n_chk++;
    if (guard >= 10) begin
      n_fail++;
      $display("FAIL b2b_done got=%b exp=1", ifa.done);
    end
    drive(1, 3, 0, 1);
    tick();
    drive(0, 0, 1, 0);
    n_chk++;
    if (ifa.busy !== 1'b1 || ifa.val !== 4'd3) begin
      n_fail++;
      $display("FAIL b2b_restart got=%b/%0d exp=1/3", ifa.busy, ifa.val);
    end
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL b2b c%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    drive(1, 9, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    while (ifa.val !== 4'd3 && guard < 20) begin
      tick();
      guard++;
    end
    #2 areset_n = 1'b0;
    m_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs[k] !== 7'h00) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got=%h exp=00", k, obs[k]);
      end
    end
    @(negedge clk);
    areset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL post_reset c%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 8) == 0, int'($urandom % 16),
            ($urandom % 4) != 0, ($urandom % 16) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random c%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
        end
      end
    end
    drive(0, 0, 0, 1);
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_count_basic();
    test_clamp();
    test_enable_toggle();
    test_stop_reload();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/downcount_timer.md
Name: downcount_timer

Overview:
- Loadable down-counter timer; the counting-down counterpart of the team's modulo-N up-counter family.
- Software or an FSM loads a start value; the block decrements on each enabled cycle and flags the last count (o_last).
- It then emits a one-cycle completion pulse (o_done).
- Used as a delay/timeout generator beside the up-counters in the lab datapaths.

Parameters:
- N, 16, modulus; legal count values are 0..N-1; N >= 2.
- W, $clog2(N), width of the value ports; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- areset_n  input  1  asynchronous active-low reset.
- i_load  input  1  load request; samples i_load_val.
- i_load_val  input  W  start value.
- i_enable  input  1  decrement enable; low = pause/hold.
- i_stop  input  1  abort a running count; no completion pulse.
- o_val  output  W  current count value.
- o_last  output  1  high while running with o_val == 0.
- o_busy  output  1  high while in S_RUN.
- o_done  output  1  one-cycle pulse on count completion.

Behaviour:
- Reset (areset_n low, asynchronous, any state):
  - State S_IDLE.
  - o_val = 0, o_busy = 0, o_last = 0, o_done = 0.
  - Reload register = 0.
  - Release is synchronous to clk.
- States: S_IDLE, S_RUN, S_DONE. All outputs except o_val are decoded from the state (no extra latency).
- Load clamp: loaded value = i_load_val if i_load_val <= N-1, else N-1.
- S_IDLE:
  - i_load=1: o_val <= clamped value, reload register <= same, next state S_RUN. o_busy is high the cycle after i_load.
  - Otherwise hold; o_val keeps its last value.
- S_RUN, priority order:
  1. i_stop: go to S_IDLE, o_val held, no o_done.
  2. i_load: restart with the new clamped value, stay in S_RUN.
  3. i_enable=1 and o_val != 0: o_val <= o_val - 1.
  4. i_enable=1 and o_val == 0: go to S_DONE, o_val stays 0.
  5. i_enable=0: hold everything.
- o_last = (state == S_RUN) && (o_val == 0). It is combinational from registers.
- Load value 0: o_last is high the first RUN cycle; the first enabled cycle then completes the count.
- Latency: load value V with i_enable held high gives o_done exactly V+1 enabled cycles after the first RUN cycle.
- S_DONE:
  - o_done = 1 for exactly one cycle, o_busy = 0.
  - Next state S_IDLE; if i_load is high in that cycle, next state is S_RUN with the new value (back-to-back timers).
  - i_stop and i_enable are ignored in S_DONE.
- No wrap-around: o_val never goes below 0 and never exceeds N-1.

Optional Feature:
- Macro: DOWNCOUNT_AUTORELOAD_EN.
- Defined:
  - In S_RUN, i_enable=1 with o_val == 0 reloads o_val from the reload register and stays in S_RUN.
  - o_done pulses high for that one cycle while o_busy stays high.
  - S_DONE is never entered; only i_stop or reset leave S_RUN.
  - Result is a periodic tick of period (reload+1) enabled cycles.
- Undefined: one-shot behaviour exactly as described above.
- The port list is identical in both builds.

Decomposition:
- Package downcount_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_RUN, S_DONE}.
  - Function clamp_load(value, N).
- Single module: one state register block, one o_val/reload register block, combinational output decode.
- No sub-module is natural; the datapath is a single W-bit register plus comparator.

Test Plan:
- N=16, reset, load 5, i_enable=1 constantly -> o_val 5,4,3,2,1,0; o_last high only when o_val=0; o_done pulses exactly 6 cycles after the first RUN cycle; o_busy then low.
- N=12, load 15 -> o_val=11 (clamped); count completes after 12 enabled cycles; o_val never exceeds 11.
- Load 7, toggle i_enable every other cycle -> o_val decrements only on enabled cycles; o_done after 8 enabled cycles (about 16 clocks).
- Load 9, at o_val=4 assert i_stop -> S_IDLE with o_val held at 4, o_busy=0, no o_done; at o_val=4 assert i_load with 2 instead -> restarts at 2.
- Pull areset_n low mid-count (o_val=3), asynchronously between edges -> all outputs 0 immediately; after release, no activity until i_load.
- DOWNCOUNT_AUTORELOAD_EN build, load 3, i_enable=1 -> o_done pulses every 4 cycles; o_busy stays high; sequence 3,2,1,0,3,2,...; i_stop ends it.
